// File: rtl/gray_stream_pkg.sv
// Shared types for the gray-word stream: pixel/word widths, the RGB888 layout
// and the gray-to-RGB mapping used on the display side.
package gray_stream_pkg;

    localparam int unsigned PIXEL_W         = 8;
    localparam int unsigned PIXELS_PER_WORD = 4;
    localparam int unsigned WORD_W          = PIXEL_W * PIXELS_PER_WORD;
    localparam int unsigned RGB_W           = 3 * PIXEL_W;

    typedef logic [PIXEL_W-1:0] gray_t;

    typedef struct packed {
        gray_t r;
        gray_t g;
        gray_t b;
    } rgb888_t;

    function automatic rgb888_t gray_to_rgb(gray_t g);
        rgb888_t p;
        p.r = g;
        p.g = g;
        p.b = g;
        return p;
    endfunction

    // Counter width for a 0..n-1 range; a range of one still needs one bit.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grayscale_to_rgb_unpacker_if.sv
// Stream bundle of the unpacker: packed gray words in, RGB888 pixels with
// line/frame markers out. master = stream source/sink side, slave = unpacker.
interface grayscale_to_rgb_unpacker_if;
    import gray_stream_pkg::*;

    logic [WORD_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [RGB_W-1:0]  m_rgb_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              m_last_o;
    logic              m_user_o;

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o,
        input  m_rgb_o,
        input  m_valid_o,
        output m_ready_i,
        input  m_last_o,
        input  m_user_o
    );

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o,
        output m_rgb_o,
        output m_valid_o,
        input  m_ready_i,
        output m_last_o,
        output m_user_o
    );

endinterface

// File: rtl/frame_position_counter.sv
// Column/row position of the current output pixel within a frame; advances
// once per delivered pixel and wraps at the line and frame boundaries.
module frame_position_counter
    import gray_stream_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned LINES       = 480,
    localparam int unsigned COL_W      = cnt_w(LINE_PIXELS),
    localparam int unsigned ROW_W      = cnt_w(LINES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             line_end_o,
    output logic             frame_start_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o         = col_q;
    assign row_o         = row_q;
    assign line_end_o    = (col_q == COL_LAST);
    assign frame_start_o = (col_q == '0) && (row_q == '0);

endmodule

// File: rtl/grayscale_to_rgb_unpacker.sv
// Unpacks 32-bit words of four gray pixels into one RGB888 pixel per handshake,
// tagging line-end (m_last_o) and frame-start (m_user_o) for the video sink.
module grayscale_to_rgb_unpacker
    import gray_stream_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned LINES       = 480
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    grayscale_to_rgb_unpacker_if.slave  bus
);

    localparam int unsigned COL_W = cnt_w(LINE_PIXELS);
    localparam int unsigned ROW_W = cnt_w(LINES);

    generate
        if ((LINE_PIXELS % PIXELS_PER_WORD) != 0 || LINE_PIXELS < PIXELS_PER_WORD
            || LINES < 1) begin : g_bad_params
            $error("grayscale_to_rgb_unpacker: LINE_PIXELS must be a multiple of 4 (>=4), LINES >= 1");
        end
    endgenerate

    logic [WORD_W-1:0] word_q, word_d;
    logic [2:0]        rem_q, rem_d;
    logic [1:0]        pix_idx;
    gray_t             pix;
    logic              out_valid;
    logic              out_hs;
    logic              in_hs;
    logic              s_ready;
    logic              line_end;
    logic              frame_start;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              pos_unused;

    // rem_q counts down 4..1, so the pixel on display is 4 - rem_q.
    assign out_valid = (rem_q != 3'd0);
    assign pix_idx   = 2'(3'(PIXELS_PER_WORD) - rem_q);
    assign pix       = word_q[PIXEL_W*pix_idx +: PIXEL_W];

    // Refill while the last pixel leaves so words stream without a bubble.
    assign s_ready = !clear_i &&
                     ((rem_q == 3'd0) || ((rem_q == 3'd1) && bus.m_ready_i));
    assign in_hs   = bus.s_valid_i && s_ready;
    assign out_hs  = out_valid && bus.m_ready_i;

    always_comb begin
        word_d = word_q;
        rem_d  = rem_q;
        if (clear_i) begin
            rem_d = 3'd0;
        end else if (in_hs) begin
            word_d = bus.s_data_i;
            rem_d  = 3'(PIXELS_PER_WORD);
        end else if (out_hs) begin
            rem_d = rem_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            rem_q  <= 3'd0;
        end else begin
            word_q <= word_d;
            rem_q  <= rem_d;
        end
    end

    frame_position_counter #(
        .LINE_PIXELS (LINE_PIXELS),
        .LINES       (LINES)
    ) u_pos (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .advance_i     (out_hs),
        .col_o         (col),
        .row_o         (row),
        .line_end_o    (line_end),
        .frame_start_o (frame_start)
    );

    // Raw position is only a debug tap here; markers come from the counter flags.
    assign pos_unused = ^{col, row};

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = out_valid;
    assign bus.m_rgb_o   = out_valid ? gray_to_rgb(pix) : '0;
    assign bus.m_last_o  = out_valid && line_end;
    assign bus.m_user_o  = out_valid && frame_start;

endmodule

// File: tb/tb_grayscale_to_rgb_unpacker.sv
// Directed bench for the gray-to-RGB unpacker with an 8x2 frame so line and
// frame markers show up within a few words.
module tb_grayscale_to_rgb_unpacker;

    localparam int TB_LP    = 8;
    localparam int TB_LINES = 2;

    logic clk;
    logic rst_n;
    logic clear;
    int   n_tests;
    int   n_fail;
    int   pix_no;

    logic [31:0] bw [3];

    grayscale_to_rgb_unpacker_if bus ();

    grayscale_to_rgb_unpacker #(
        .LINE_PIXELS (TB_LP),
        .LINES       (TB_LINES)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Expects a valid pixel of gray level g that will be taken this cycle.
    task automatic see_pixel(input string tag, input logic [7:0] g);
        chk({tag, ".vld"},  {31'd0, bus.m_valid_o}, 32'd1);
        chk({tag, ".rgb"},  {8'd0, bus.m_rgb_o}, {8'd0, g, g, g});
        chk({tag, ".last"}, {31'd0, bus.m_last_o}, {31'd0, (pix_no % TB_LP) == TB_LP - 1});
        chk({tag, ".user"}, {31'd0, bus.m_user_o}, {31'd0, (pix_no % (TB_LP*TB_LINES)) == 0});
        pix_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pix_no  = 0;
        bw[0] = 32'h17161514;
        bw[1] = 32'h1b1a1918;
        bw[2] = 32'h1f1e1d1c;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.s_data_i  = '0;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.s_data_i  = $urandom;
            bus.s_valid_i = 1'($urandom_range(0, 1));
            bus.m_ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("rst.vld", {31'd0, bus.m_valid_o}, 32'd0);
            chk("rst.rgb", {8'd0, bus.m_rgb_o}, 32'd0);
        end
        chk("rst.last", {31'd0, bus.m_last_o}, 32'd0);
        chk("rst.user", {31'd0, bus.m_user_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.s_valid_i = 1'b0;
        #1;
        chk("rst.s_ready", {31'd0, bus.s_ready_o}, 32'd1);

        // single word
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'h40302010;
        bus.m_ready_i = 1'b1;
        #1;
        chk("one.s_ready", {31'd0, bus.s_ready_o}, 32'd1);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1 see_pixel("one.p0", 8'h10);
        @(negedge clk); #1 see_pixel("one.p1", 8'h20);
        @(negedge clk); #1 see_pixel("one.p2", 8'h30);
        @(negedge clk); #1;
        chk("one.p3.s_ready", {31'd0, bus.s_ready_o}, 32'd1);
        see_pixel("one.p3", 8'h40);
        @(negedge clk); #1;
        chk("one.idle", {31'd0, bus.m_valid_o}, 32'd0);

        // back-to-back words, m_ready held high
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = bw[0];
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    if (w < 2) bus.s_data_i = bw[w+1];
                    else       bus.s_valid_i = 1'b0;
                end
                #1;
                see_pixel("b2b", bw[w][8*k +: 8]);
                if (k == 3 && w < 2)
                    chk("b2b.s_ready", {31'd0, bus.s_ready_o}, 32'd1);
            end
        end

        // fifth word: new frame, then backpressure on pixel 1
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'h40302010;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1 see_pixel("bp.p0", 8'h10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.m_ready_i = 1'b0;
            #1;
            chk("bp.hold.vld", {31'd0, bus.m_valid_o}, 32'd1);
            chk("bp.hold.rgb", {8'd0, bus.m_rgb_o}, 32'h00202020);
            chk("bp.hold.s_ready", {31'd0, bus.s_ready_o}, 32'd0);
            chk("bp.hold.user", {31'd0, bus.m_user_o}, 32'd0);
            chk("bp.hold.last", {31'd0, bus.m_last_o}, 32'd0);
        end
        @(negedge clk);
        bus.m_ready_i = 1'b1;
        #1 see_pixel("bp.p1", 8'h20);
        @(negedge clk); #1 see_pixel("bp.p2", 8'h30);
        @(negedge clk); #1 see_pixel("bp.p3", 8'h40);

        // clear with two pixels pending
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'hddccbbaa;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1 see_pixel("clr.p0", 8'haa);
        @(negedge clk); #1 see_pixel("clr.p1", 8'hbb);
        @(negedge clk);
        clear = 1'b1;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'h77665544;
        #1;
        chk("clr.rgb", {8'd0, bus.m_rgb_o}, 32'h00cccccc);
        chk("clr.s_ready", {31'd0, bus.s_ready_o}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr.after.vld", {31'd0, bus.m_valid_o}, 32'd0);
        chk("clr.after.s_ready", {31'd0, bus.s_ready_o}, 32'd1);
        pix_no = 0;
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1 see_pixel("clr.n0", 8'h44);
        @(negedge clk); #1 see_pixel("clr.n1", 8'h55);
        @(negedge clk); #1 see_pixel("clr.n2", 8'h66);
        @(negedge clk); #1 see_pixel("clr.n3", 8'h77);
        @(negedge clk); #1;
        chk("clr.idle", {31'd0, bus.m_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grayscale_to_rgb_unpacker.md
Name: grayscale_to_rgb_unpacker

Overview:
Streaming converter on the display side of the pipeline. It accepts 32-bit words, each packing four 8-bit grayscale pixels. It emits one RGB888 pixel per handshake with r = g = b = gray, and tracks line and frame position. Line-end and frame-start markers are generated for the downstream video sink.

Parameters:
LINE_PIXELS, 640, pixels per line; must be a multiple of 4 and at least 4.
LINES, 480, lines per frame; must be at least 1.

Ports:
clk_i  input  1  single clock; all logic is rising-edge.
rst_ni  input  1  asynchronous active-low reset.
clear_i  input  1  synchronous flush of the buffer and position counters.
s_data_i  input  32  four gray pixels; pixel 0 is [7:0], pixel 3 is [31:24].
s_valid_i  input  1  input word valid.
s_ready_o  output  1  input word accepted when s_valid_i && s_ready_o.
m_rgb_o  output  24  {r[23:16], g[15:8], b[7:0]}.
m_valid_o  output  1  output pixel valid.
m_ready_i  input  1  downstream ready.
m_last_o  output  1  current pixel is the last pixel of its line.
m_user_o  output  1  current pixel is the first pixel of the frame.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- State:
  - word_q[31:0]: held input word.
  - rem_q[2:0]: pixels remaining, 0..4.
  - col_q: 0..LINE_PIXELS-1.
  - row_q: 0..LINES-1.
- Reset values: word_q=0, rem_q=0, col_q=0, row_q=0.
  - Resulting outputs: m_valid_o=0, m_rgb_o=0, m_last_o=0, m_user_o=0.
  - s_ready_o=1 once rst_ni is high and clear_i is low.
- Output decode:
  - m_valid_o = (rem_q != 0).
  - The pixel index is 4 - rem_q, selecting byte word_q[8*idx +: 8].
  - That byte drives all three colour fields of m_rgb_o. When rem_q=0, m_rgb_o=0.
- Markers:
  - m_last_o = m_valid_o && col_q == LINE_PIXELS-1.
  - m_user_o = m_valid_o && col_q == 0 && row_q == 0.
- Input ready: s_ready_o = !clear_i && (rem_q == 0 || (rem_q == 1 && m_ready_i)).
  - This is a combinational path from m_ready_i and gives gap-free 1 pixel/clock throughput.
- Latency: the first pixel of an accepted word appears with m_valid_o=1 in the cycle after the input handshake.
- Per-clock update, when clear_i=0:
  - Input accept: word_q <= s_data_i, rem_q <= 4. If an output handshake happens in the same cycle (rem_q was 1), the accept still yields rem_q=4.
  - Output handshake only: rem_q <= rem_q - 1.
  - Neither: hold all state. m_rgb_o, m_last_o and m_user_o must stay stable while m_valid_o && !m_ready_i (AXI-Stream rule).
- Position counters advance only on an output handshake:
  - col_q increments; at LINE_PIXELS-1 it wraps to 0 and row_q increments.
  - row_q wraps to 0 after LINES-1.
- clear_i=1: rem_q <= 0, col_q <= 0, row_q <= 0.
  - Any pending pixels are dropped, even if an output handshake occurs that cycle.
  - No input is accepted that cycle. word_q is don't-care.
- Reset asserted mid-word: all state clears immediately. Partial pixels are lost; no marker is emitted.
- Arithmetic: counters are sized with $clog2, with no overflow beyond the wrap points. The colour mapping is a pure copy with no rounding.

Decomposition:
- Package gray_stream_pkg:
  - PIXEL_W = 8, PIXELS_PER_WORD = 4.
  - typedef gray_t (logic [7:0]).
  - typedef struct packed rgb888_t {r, g, b}.
  - function gray_to_rgb(gray_t) returning rgb888_t.
- One sub-module, frame_position_counter:
  - Parameters LINE_PIXELS and LINES.
  - Inputs advance_i and clear_i.
  - Outputs col_o, row_o, line_end_o, frame_start_o.
- The top level keeps the word buffer, rem_q and the handshake logic.

Test Plan:
- Reset check: hold rst_ni=0 with random inputs -> m_valid_o=0 and m_rgb_o=0. After release, s_ready_o=1.
- Single word 32'h40302010 with m_ready_i=1 -> over 4 cycles m_rgb_o = 24'h101010, 202020, 303030, 404040; s_ready_o=1 in the 4th output cycle.
- Back-to-back words with m_ready_i held at 1 -> m_valid_o never drops between words; throughput is exactly 1 pixel/clock.
- Backpressure: m_ready_i=0 for 5 cycles while showing pixel 24'h202020 -> output is stable, s_ready_o=0, no pixel is lost or duplicated.
- Markers with LINE_PIXELS=8, LINES=2:
  - Stream 4 words -> m_user_o on pixel 0 only; m_last_o on pixels 7 and 15.
  - A 5th word -> m_user_o again on pixel 16.
- clear_i asserted while rem_q=2 with s_valid_i=1 -> no accept that cycle; next cycle m_valid_o=0. The next word starts at col 0 / row 0 with m_user_o=1.
